mp_mem_responder: RTL and testbench

- Responder end of the core-to-memory request interface: clk, core_id, opcode, addr, data_in, data_out, req, gnt, we, rvalid, burst_id.
- Accepts single and fixed-length burst read/write requests from the core side and grants them one at a time.
- Holds a word-addressed local memory and returns read data with a fixed latency, tagged with the requester's core_id and burst_id.
- Replaces the stub DUT behind the interface as the shared-memory target for multiprocessor tests.

---
 rtl/mp_mem_pkg.sv | 29 ++
 rtl/mp_mem_array.sv | 28 ++
 rtl/mp_mem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_mp_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp_mem_pkg.sv
// Shared types, default widths and helpers for the multiprocessor memory responder.
package mp_mem_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_CORE_W    = 2;
  localparam int DEF_BID_W     = 4;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_RD_LAT    = 2;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_SINGLE = 2'b01,
    OP_BURST  = 2'b10,
    OP_RSVD   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WR_BURST = 2'b01,
    RD_WAIT  = 2'b10,
    RD_DATA  = 2'b11
  } state_e;

  function automatic int beats_for(input opcode_e op, input int burst_len);
    return (op == OP_BURST) ? burst_len : 1;
  endfunction

endpackage

// File: rtl/mp_mem_array.sv
// Word-addressed storage: one write port, one synchronous read port, no reset.
module mp_mem_array
  import mp_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/mp_mem_responder.sv
// Memory responder: grants single/burst requests one at a time, fixed read latency.
// Optional macro MP_MEM_RESP_ERR_EN adds the err output (reserved opcode / burst wrap).
module mp_mem_responder
  import mp_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CORE_W    = DEF_CORE_W,
  parameter int BID_W     = DEF_BID_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [CORE_W-1:0] core_id,
  input  logic [1:0]        opcode,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [BID_W-1:0]  burst_id,
  output logic              gnt,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic [CORE_W-1:0] rsp_core_id,
  output logic [BID_W-1:0]  rsp_burst_id,
  output logic              busy
`ifdef MP_MEM_RESP_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d, busy_q, busy_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [CORE_W-1:0] rsp_core_q, rsp_core_d;
  logic [BID_W-1:0]  rsp_bid_q, rsp_bid_d;
  logic [ADDR_W-1:0] addr_q, addr_d, raddr_q, raddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, rd_left_q, rd_left_d;
  logic [WAIT_W-1:0] rd_wait_q, rd_wait_d;
  logic              rd_pend_q, rd_pend_d, rsvd_q, rsvd_d;
  logic              wr_en_s, rd_en_s, rsvd_hit_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [CNT_W-1:0]  nbeats_s;
  opcode_e           op_s;

  assign op_s     = opcode_e'(opcode);
  assign nbeats_s = CNT_W'(beats_for(op_s, BURST_LEN));

`ifdef MP_MEM_RESP_ERR_EN
  logic              err_q, err_d;
  logic [ADDR_W:0]   end_addr_s;
  assign rsvd_hit_s = (op_s == OP_RSVD);
  assign end_addr_s = {1'b0, addr} + (ADDR_W + 1)'(BURST_LEN - 1);
  assign err        = err_q;
`else
  assign rsvd_hit_s = 1'b0;
`endif

  // Next-state, grant/response sequencing and the read-issue engine.
  always_comb begin
    state_d    = state_q;
    gnt_d      = 1'b0;
    busy_d     = busy_q;
    rvalid_d   = 1'b0;
    data_out_d = data_out_q;
    rsp_core_d = rsp_core_q;
    rsp_bid_d  = rsp_bid_q;
    addr_d     = addr_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    rd_left_d  = rd_left_q;
    rd_wait_d  = rd_wait_q;
    rd_pend_d  = 1'b0;
    rsvd_d     = rsvd_q;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    rd_addr_s  = raddr_q;
`ifdef MP_MEM_RESP_ERR_EN
    err_d      = 1'b0;
`endif

    // Array reads run one edge ahead of rvalid because data_out is a second register stage.
    if (rd_left_q != CNT_W'(0)) begin
      if (rd_wait_q != WAIT_W'(0)) begin
        rd_wait_d = rd_wait_q - WAIT_W'(1);
      end else begin
        rd_en_s   = 1'b1;
        rd_pend_d = 1'b1;
        rd_left_d = rd_left_q - CNT_W'(1);
        raddr_d   = raddr_q + ADDR_W'(1);
      end
    end else begin
      rd_wait_d = rd_wait_q;
    end

    if (rd_pend_q) begin
      rvalid_d   = 1'b1;
      data_out_d = rd_data_s;
    end else begin
      data_out_d = data_out_q;
    end

    case (state_q)
      IDLE: begin
        if (req && (op_s != OP_NOP)) begin
          gnt_d  = 1'b1;
          busy_d = 1'b1;
          addr_d = addr;
          rsvd_d = rsvd_hit_s;
`ifdef MP_MEM_RESP_ERR_EN
          err_d  = rsvd_hit_s || ((op_s == OP_BURST) && end_addr_s[ADDR_W]);
`endif
          if (rsvd_hit_s || we) begin
            state_d = WR_BURST;
            cnt_d   = rsvd_hit_s ? CNT_W'(1) : nbeats_s;
          end else begin
            state_d    = RD_WAIT;
            rsp_core_d = core_id;
            rsp_bid_d  = burst_id;
            if (RD_LAT == 1) begin
              rd_en_s   = 1'b1;
              rd_addr_s = addr;
              rd_pend_d = 1'b1;
              rd_left_d = nbeats_s - CNT_W'(1);
              raddr_d   = addr + ADDR_W'(1);
              rd_wait_d = WAIT_W'(0);
            end else begin
              rd_left_d = nbeats_s;
              raddr_d   = addr;
              rd_wait_d = WAIT_W'(RD_LAT - 2);
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        wr_en_s = req && gnt_q && !rsvd_q;
        cnt_d   = cnt_q - CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gnt_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rd_pend_q) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_DATA: begin
        // The last beat is on the bus when no further read is in the pipe.
        if (!rd_pend_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = RD_DATA;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, tags and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      data_out_q <= '0;
      rsp_core_q <= '0;
      rsp_bid_q  <= '0;
      addr_q     <= '0;
      raddr_q    <= '0;
      cnt_q      <= '0;
      rd_left_q  <= '0;
      rd_wait_q  <= '0;
      rd_pend_q  <= 1'b0;
      rsvd_q     <= 1'b0;
`ifdef MP_MEM_RESP_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
      data_out_q <= data_out_d;
      rsp_core_q <= rsp_core_d;
      rsp_bid_q  <= rsp_bid_d;
      addr_q     <= addr_d;
      raddr_q    <= raddr_d;
      cnt_q      <= cnt_d;
      rd_left_q  <= rd_left_d;
      rd_wait_q  <= rd_wait_d;
      rd_pend_q  <= rd_pend_d;
      rsvd_q     <= rsvd_d;
`ifdef MP_MEM_RESP_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  mp_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en_s),
    .wr_addr(addr_q),
    .wr_data(data_in),
    .rd_en  (rd_en_s),
    .rd_addr(rd_addr_s),
    .rd_data(rd_data_s)
  );

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign rvalid       = rvalid_q;
  assign data_out     = data_out_q;
  assign rsp_core_id  = rsp_core_q;
  assign rsp_burst_id = rsp_bid_q;

endmodule

// File: tb/tb_mp_mem_responder.sv
// Randomized self-checking bench: a transaction-level timeline model predicts every output cycle.
module tb_mp_mem_responder;

  localparam int ADDR_W = 8, DATA_W = 32, CORE_W = 2, BID_W = 4;
  localparam int BL = 4, RD_LAT = 2, DEPTH = 256, NCYC = 8192;

  logic              clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [1:0]        opcode = 2'b00;
  logic [CORE_W-1:0] core_id = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [BID_W-1:0]  burst_id = '0;
  logic              gnt, rvalid, busy;
  logic [DATA_W-1:0] data_out;
  logic [CORE_W-1:0] rsp_core_id;
  logic [BID_W-1:0]  rsp_burst_id;
`ifdef MP_MEM_RESP_ERR_EN
  logic              err;
`endif

  mp_mem_responder dut (
    .clk(clk), .reset(reset), .req(req), .core_id(core_id), .opcode(opcode), .we(we),
    .addr(addr), .data_in(data_in), .burst_id(burst_id), .gnt(gnt), .data_out(data_out),
    .rvalid(rvalid), .rsp_core_id(rsp_core_id), .rsp_burst_id(rsp_burst_id), .busy(busy)
`ifdef MP_MEM_RESP_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by the edge after which they are visible.
  bit          exp_gnt [NCYC], exp_busy [NCYC], exp_rvalid [NCYC], exp_err [NCYC];
  logic [31:0] exp_data [NCYC];
  logic [1:0]  exp_core [NCYC];
  logic [3:0]  exp_bid [NCYC];
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] wdata_q [$];
  int          next_ok = 0, vectors = 0, miscompares = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) step();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", {31'd0, gnt}, {31'd0, exp_gnt[cyc]});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
      chk("rvalid", {31'd0, rvalid}, {31'd0, exp_rvalid[cyc]});
`ifdef MP_MEM_RESP_ERR_EN
      chk("err", {31'd0, err}, {31'd0, exp_err[cyc]});
`endif
      if (exp_rvalid[cyc]) begin
        chk("data_out", data_out, exp_data[cyc]);
        chk("rsp_core_id", {30'd0, rsp_core_id}, {30'd0, exp_core[cyc]});
        chk("rsp_burst_id", {28'd0, rsp_burst_id}, {28'd0, exp_bid[cyc]});
      end
    end
  end

  // Issues one transaction; returns the edge n at which the DUT samples it.
  task automatic run_txn(input logic [1:0] opc, input bit w, input logic [7:0] a,
                         input logic [1:0] cid, input logic [3:0] bid, input bit early,
                         input int drop_pct, output int n);
    int nb, idx;
    bit rsvd_err;
    logic [31:0] d;
    n = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
    if (!early) while (cyc + 1 < n) step();
    req = 1'b1; opcode = opc; we = w; addr = a; core_id = cid; burst_id = bid;
    data_in = $urandom;
    wait_to(n);
    nb = (opc == 2'b10) ? BL : 1;
    rsvd_err = 1'b0;
`ifdef MP_MEM_RESP_ERR_EN
    rsvd_err = (opc == 2'b11);
    if (opc == 2'b10 && int'(a) + BL - 1 >= DEPTH) exp_err[n] = 1'b1;
`endif
    if (rsvd_err) begin
      exp_err[n] = 1'b1; exp_gnt[n] = 1'b1; exp_busy[n] = 1'b1;
      req = 1'b0;
      next_ok = n + 2;
    end else if (w) begin
      for (int k = 0; k < nb; k++) begin
        exp_gnt[n + k] = 1'b1;
        exp_busy[n + k] = 1'b1;
      end
      for (int k = 0; k < nb; k++) begin
        d = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
        req = ($urandom_range(99) >= drop_pct);
        data_in = d;
        if (req) mdl_mem[(int'(a) + k) % DEPTH] = d;
        step();
      end
      req = 1'b0;
      next_ok = n + nb + 1;
    end else begin
      req = 1'b0;
      exp_gnt[n] = 1'b1;
      for (int k = 0; k < RD_LAT + nb; k++) exp_busy[n + k] = 1'b1;
      for (int k = 0; k < nb; k++) begin
        idx = n + RD_LAT + k;
        exp_rvalid[idx] = 1'b1;
        exp_data[idx] = mdl_mem[(int'(a) + k) % DEPTH];
        exp_core[idx] = cid;
        exp_bid[idx] = bid;
      end
      next_ok = n + RD_LAT + nb + 1;
    end
    opcode = 2'b00;
  endtask

  task automatic nop_blip(input int len);
    while (cyc + 1 < next_ok) step();
    req = 1'b1; opcode = 2'b00; we = $urandom_range(1); addr = 8'h10; data_in = $urandom;
    for (int i = 0; i < len; i++) step();
    req = 1'b0;
  endtask

  initial begin
    int n, n1, n2;
    bit prev_rd;
    logic [1:0] opc;
    logic [7:0] a;

    step(); step();
    chk("reset_gnt", {31'd0, gnt}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    for (int b = 0; b < DEPTH / BL; b++) run_txn(2'b10, 1'b1, 8'(b * BL), 2'd0, 4'd0, 1'b0, 0, n);

    // Single write then single read with fixed literal expectations.
    wdata_q.push_back(32'hDEADBEEF);
    run_txn(2'b01, 1'b1, 8'h10, 2'd2, 4'd1, 1'b0, 0, n);
    run_txn(2'b01, 1'b0, 8'h10, 2'd2, 4'd5, 1'b0, 0, n);
    chk("single_rd_gnt", {31'd0, gnt}, 32'd1);
    wait_to(n + RD_LAT - 1);
    chk("single_rd_early_rvalid", {31'd0, rvalid}, 32'd0);
    wait_to(n + RD_LAT);
    chk("single_rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("single_rd_data", data_out, 32'hDEADBEEF);
    chk("single_rd_core", {30'd0, rsp_core_id}, 32'd2);
    chk("single_rd_bid", {28'd0, rsp_burst_id}, 32'd5);

    // Burst across the top address.
    for (int k = 0; k < BL; k++) wdata_q.push_back(32'h11 * (k + 1));
    run_txn(2'b10, 1'b1, 8'hFE, 2'd1, 4'd2, 1'b0, 0, n);
    run_txn(2'b10, 1'b0, 8'hFE, 2'd3, 4'd9, 1'b0, 0, n);
    for (int k = 0; k < BL; k++) begin
      wait_to(n + RD_LAT + k);
      chk("wrap_burst_data", data_out, 32'h11 * (k + 1));
    end

    // Request held high during a read burst is only taken after the return to idle.
    run_txn(2'b10, 1'b0, 8'h20, 2'd1, 4'd3, 1'b0, 0, n1);
    run_txn(2'b01, 1'b0, 8'h10, 2'd0, 4'd7, 1'b1, 0, n2);
    chk("busy_hold_sample_edge", 32'(n2 - n1), 32'd7);
    chk("busy_hold_gnt", {31'd0, gnt}, 32'd1);

    nop_blip(5);

    // Reset during the read data phase.
    run_txn(2'b10, 1'b0, 8'h40, 2'd1, 4'd4, 1'b0, 0, n);
    wait_to(n + RD_LAT + 1);
    for (int i = cyc; i < NCYC; i++) begin
      exp_gnt[i] = 1'b0; exp_busy[i] = 1'b0; exp_rvalid[i] = 1'b0; exp_err[i] = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("midrst_gnt", {31'd0, gnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b0;
    next_ok = 0;
    run_txn(2'b01, 1'b0, 8'h10, 2'd3, 4'd6, 1'b0, 0, n);
    wait_to(n + RD_LAT);
    chk("post_rst_data", data_out, 32'hDEADBEEF);

    // Reserved opcode write.
    wdata_q.push_back(32'h12345678);
    run_txn(2'b11, 1'b1, 8'h10, 2'd1, 4'd8, 1'b0, 0, n);
    run_txn(2'b01, 1'b0, 8'h10, 2'd1, 4'd8, 1'b0, 0, n);
    wait_to(n + RD_LAT);
`ifdef MP_MEM_RESP_ERR_EN
    chk("rsvd_no_write", data_out, 32'hDEADBEEF);
`else
    chk("rsvd_as_single", data_out, 32'h12345678);
`endif
    wdata_q.delete();

    prev_rd = 1'b1;
    for (int t = 0; t < 250 && cyc < NCYC - 200; t++) begin
      if ($urandom_range(9) == 0) nop_blip(2);
      for (int g = $urandom_range(2); g > 0; g--) step();
      opc = 2'($urandom_range(3, 1));
      a = ($urandom_range(3) == 0) ? 8'(252 + $urandom_range(3)) : 8'($urandom_range(255));
      run_txn(opc, 1'($urandom_range(1)), a, 2'($urandom_range(3)), 4'($urandom_range(15)),
              prev_rd && ($urandom_range(3) == 0), 15, n);
      prev_rd = !we;
    end

    wait_to(next_ok + 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
